input_data_handler: RTL and testbench



---
 rtl/input_data_handler.sv | 218 +++++++++++++++++++++
 tb/tb_input_data_handler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_data_handler.sv
// UART receiver plus 64-byte block packer feeding sha_256_fsm_v1; holds the block until hash_done.
// Optional inter-byte timeout on partial blocks is enabled with `define IDH_TIMEOUT_EN.
module input_data_handler #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_uart_rx,
    input  logic         i_hash_done,
    input  logic         i_clr_err,
    output logic [511:0] o_block,
    output logic         sha_start,
    output logic         o_busy,
    output logic [6:0]   o_byte_cnt,
    output logic         o_frame_err,
    output logic         o_overrun,
    output logic         o_timeout
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);

    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("input_data_handler: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [2:0] {RX_WAIT_IDLE, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {COLLECT, START, WAIT_HASH} blk_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid, stop_err;

    blk_state_e       blk_state_q, blk_state_d;
    logic [511:0]     block_q, block_d;
    logic [6:0]       byte_cnt_q, byte_cnt_d;
    logic             ferr_q, ferr_d, ovr_q, ovr_d;
    logic             tmo_fire;
    logic [8:0]       wr_base;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (rx_state_q)
            RX_WAIT_IDLE: begin
                // Needs one full bit period of unbroken high line before listening.
                if (!rx_sync_q) begin
                    rx_cnt_d = '0;
                end else if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_BIT) begin
                    rx_cnt_d   = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    shift_d  = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                   bit_idx_d  = bit_idx_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        stop_err   = 1'b1;
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_WAIT_IDLE;
            rx_cnt_q   <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= i_uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Byte k lands at o_block[511-8k -: 8]; for 6-bit k that base is {~k, 3'b000}.
    assign wr_base = {~byte_cnt_q[5:0], 3'b000};

    always_comb begin
        blk_state_d = blk_state_q;
        block_d     = block_q;
        byte_cnt_d  = byte_cnt_q;
        case (blk_state_q)
            COLLECT: begin
                if (byte_valid) begin
                    block_d[wr_base +: 8] = shift_q;
                    byte_cnt_d            = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 7'd63) blk_state_d = START;
                end else if (tmo_fire) begin
                    byte_cnt_d = '0;
                end
            end
            START: blk_state_d = WAIT_HASH;
            WAIT_HASH: begin
                if (i_hash_done) begin
                    byte_cnt_d  = '0;
                    blk_state_d = COLLECT;
                end
            end
            default: blk_state_d = COLLECT;
        endcase
    end

    assign ferr_d = (ferr_q & ~i_clr_err) | stop_err;
    assign ovr_d  = (ovr_q & ~i_clr_err) | (byte_valid && blk_state_q != COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_state_q <= COLLECT;
            block_q     <= '0;
            byte_cnt_q  <= '0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            blk_state_q <= blk_state_d;
            block_q     <= block_d;
            byte_cnt_q  <= byte_cnt_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

`ifdef IDH_TIMEOUT_EN
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_fire  = 1'b0;
        if (blk_state_q != COLLECT || byte_valid || byte_cnt_q == '0) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TMO_LIMIT - 1)) begin
            tmo_fire  = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_d = (tmo_q & ~i_clr_err) | tmo_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_timeout = tmo_q;
`else
    assign tmo_fire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_block     = block_q;
    assign sha_start   = (blk_state_q == START);
    assign o_busy      = (blk_state_q != COLLECT);
    assign o_byte_cnt  = byte_cnt_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_input_data_handler.sv
// Directed bench for input_data_handler: serial frames in, block/flag/start-pulse behaviour checked
// against a byte-array model of the packer plus hand-computed literal expectations.
module tb_input_data_handler;

    localparam int CPB       = 61;
    localparam int TBITS     = 20;
    localparam int TMO_LIMIT = TBITS * CPB;
    // fall of start bit -> 2 sync flops -> start detect -> half bit -> 8 data bits -> stop sample -> pulse
    localparam int SHA_LAT   = 9 * CPB + (CPB - 1) / 2 + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic         hash_done = 1'b0;
    logic         clr_err = 1'b0;
    logic [511:0] o_block;
    logic         sha_start, o_busy, o_frame_err, o_overrun, o_timeout;
    logic [6:0]   o_byte_cnt;

    input_data_handler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TBITS)) dut (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx), .i_hash_done(hash_done), .i_clr_err(clr_err),
        .o_block(o_block), .sha_start(sha_start), .o_busy(o_busy), .o_byte_cnt(o_byte_cnt),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model of what the handler must hold
    logic [7:0] m_blk[64];
    int         m_cnt = 0;
    bit         m_busy = 0, m_ferr = 0, m_ovr = 0, m_tmo = 0, m_armed = 0;
    bit         chk_en = 0, sha_pend = 0;
    int         t_fall = 0, sha_seen = 0;
    int         checks = 0, errors = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] model_block();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[511 - 8*i -: 8] = m_blk[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("block", o_block, model_block());
            check("byte_cnt", o_byte_cnt, m_cnt);
            check("busy", o_busy, m_busy);
            check("frame_err", o_frame_err, m_ferr);
            check("overrun", o_overrun, m_ovr);
            check("timeout", o_timeout, m_tmo);
        end
        if (sha_start) begin
            sha_seen++;
            check("sha_start_expected", sha_pend, 1'b1);
            check("sha_start_latency", cyc - t_fall, SHA_LAT);
            sha_pend = 0;
        end else if (sha_pend && (cyc - t_fall) > SHA_LAT) begin
            check("sha_start_missing", 1'b0, 1'b1);
            sha_pend = 0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_blk[i] = 8'h00;
        m_cnt = 0; m_busy = 0; m_ferr = 0; m_ovr = 0; m_tmo = 0; m_armed = 0; sha_pend = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        chk_en = 0;
        t_fall = cyc;
        if (m_armed && stop && !m_busy && m_cnt == 63) sha_pend = 1;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        if (m_armed) begin
            if (!stop) begin
                m_ferr = 1; m_armed = 0;
            end else if (m_busy) begin
                m_ovr = 1;
            end else begin
                m_blk[m_cnt] = b; m_cnt++;
                if (m_cnt == 64) m_busy = 1;
            end
        end
        chk_en = 1;
    endtask

    task automatic idle(input int n);
        chk_en = 0;
        repeat (n) @(posedge clk);
        #1;
        if (n >= CPB + 4) m_armed = 1;
`ifdef IDH_TIMEOUT_EN
        if (!m_busy && m_cnt >= 1 && m_cnt <= 63 && n >= TMO_LIMIT) begin
            m_cnt = 0; m_tmo = 1;
        end
`endif
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_hash_done();
        chk_en = 0;
        hash_done = 1'b1;
        @(posedge clk);
        #1;
        hash_done = 1'b0;
        if (m_busy) begin m_cnt = 0; m_busy = 0; end
        idle(1);
    endtask

    task automatic pulse_clr_err();
        chk_en = 0;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        m_ferr = 0; m_ovr = 0; m_tmo = 0;
        idle(1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_block"}, o_block, 512'd0);
        check({tag, "_cnt"}, o_byte_cnt, 7'd0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_start"}, sha_start, 1'b0);
        check({tag, "_ferr"}, o_frame_err, 1'b0);
        check({tag, "_ovr"}, o_overrun, 1'b0);
        check({tag, "_tmo"}, o_timeout, 1'b0);
    endtask

    logic [87:0] msg;
    logic [7:0]  hello[64];

    initial begin
        msg = "hello world";
        for (int i = 0; i < 64; i++) hello[i] = 8'h00;
        for (int i = 0; i < 11; i++) hello[i] = msg[87 - 8*i -: 8];
        hello[11] = 8'h80;
        hello[63] = 8'h58;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(CPB + 10);

        // partial block of 30 bytes, then reset in the middle of byte 31
        for (int i = 0; i < 30; i++) send_frame(8'(i * 3 + 1), 1'b1);
        idle(4);
        check("pre_reset_cnt", o_byte_cnt, 7'd30);
        chk_en = 0;
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx = 1'b1;
        model_reset();
        @(negedge clk);
        reset_checks("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(CPB + 10);

        // full padded "hello world" block, back-to-back frames
        sha_seen = 0;
        for (int i = 0; i < 64; i++) send_frame(hello[i], 1'b1);
        idle(4);
        check("hello_first", o_block[511:504], 8'h68);
        check("hello_last", o_block[7:0], 8'h58);
        check("hello_cnt", o_byte_cnt, 7'd64);
        check("hello_busy", o_busy, 1'b1);
        check("hello_sha_count", sha_seen, 1);

        // byte while waiting for the hash is dropped
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("ovr_set", o_overrun, 1'b1);
        check("ovr_block_kept", o_block[511:504], 8'h68);
        pulse_hash_done();
        check("done_cnt", o_byte_cnt, 7'd0);
        check("done_busy", o_busy, 1'b0);

        // bad stop bit, then an immediate frame the receiver must ignore
        send_frame(8'h3C, 1'b0);
        send_frame(8'h00, 1'b1);
        idle(CPB + 20);
        check("ferr_set", o_frame_err, 1'b1);
        check("ferr_cnt", o_byte_cnt, 7'd0);

        send_frame(8'h11, 1'b1);
        idle(4);
        check("next_byte_first", o_block[511:504], 8'h11);
        check("next_byte_old", o_block[503:496], 8'h65);

        pulse_hash_done();
        check("done_in_collect", o_byte_cnt, 7'd1);
        pulse_clr_err();
        check("clr_ferr", o_frame_err, 1'b0);
        check("clr_ovr", o_overrun, 1'b0);

        // 20-cycle glitch on the idle line
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(2 * CPB);
        check("glitch_cnt", o_byte_cnt, 7'd1);
        check("glitch_ferr", o_frame_err, 1'b0);

        // five bytes, then a long idle
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(4);
        check("five_cnt", o_byte_cnt, 7'd5);
        idle(TMO_LIMIT + 80);
`ifdef IDH_TIMEOUT_EN
        check("tmo_cnt", o_byte_cnt, 7'd0);
        check("tmo_flag", o_timeout, 1'b1);
`else
        check("tmo_cnt", o_byte_cnt, 7'd5);
        check("tmo_flag", o_timeout, 1'b0);
`endif
        check("total_sha_count", sha_seen, 1);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
